// File: rtl/jtdd_sdram_sched.sv
// jtdd_sdram_sched: four-slot ROM read scheduler with one-word tag caches and round-robin SDRAM access
module jtdd_sdram_sched #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic [3:0]    slot_cs,
    input  logic [AW-1:0] slot0_addr,
    input  logic [AW-1:0] slot1_addr,
    input  logic [AW-1:0] slot2_addr,
    input  logic [AW-1:0] slot3_addr,
    output logic [3:0]    slot_ok,
    output logic [DW-1:0] slot0_dout,
    output logic [DW-1:0] slot1_dout,
    output logic [DW-1:0] slot2_dout,
    output logic [DW-1:0] slot3_dout,
    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [DW-1:0] data_read
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
    state_t        state_q, state_d;
    logic [1:0]    cur_q, cur_d, rr_q, rr_d, gnt, idx;
    logic          req_q, req_d, drop_q, drop_d, found, fill;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] addr_in [4];
    logic [AW-1:0] tag_q [4];
    logic [AW-1:0] tag_d [4];
    logic [DW-1:0] data_q [4];
    logic [DW-1:0] data_d [4];
    logic [3:0]    valid_q, valid_d, hit, miss;
    assign addr_in[0] = slot0_addr;
    assign addr_in[1] = slot1_addr;
    assign addr_in[2] = slot2_addr;
    assign addr_in[3] = slot3_addr;
    assign slot_ok    = hit;
    assign slot0_dout = data_q[0];
    assign slot1_dout = data_q[1];
    assign slot2_dout = data_q[2];
    assign slot3_dout = data_q[3];
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    // cache lookup; the slot being served is never counted as a fresh miss
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i]  = slot_cs[i] & valid_q[i] & (addr_in[i] == tag_q[i]);
            miss[i] = slot_cs[i] & ~hit[i] & ~(state_q != IDLE && cur_q == 2'(i));
        end
    end
    // round-robin search for the first missing slot at or after rr_q
    always_comb begin
        found = 1'b0;
        gnt   = rr_q;
        idx   = rr_q;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && miss[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end
    // transaction FSM and cache fill; downloading invalidates everything and suppresses fills
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        req_d   = req_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        fill    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!downloading && found) begin
                    cur_d   = gnt;
                    addr_d  = addr_in[gnt];
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (downloading) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (sdram_ack) begin
                    req_d = 1'b0;
                    if (data_rdy) begin
                        fill    = 1'b1;
                        rr_d    = cur_q + 2'd1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                drop_d = drop_q | downloading;
                if (data_rdy) begin
                    fill    = ~(drop_q | downloading);
                    rr_d    = cur_q + 2'd1;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = downloading ? 4'b0 : valid_q;
        if (fill) begin
            tag_d[cur_q]   = addr_q;
            data_d[cur_q]  = data_read;
            valid_d[cur_q] = 1'b1;
        end
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= 2'd0;
            rr_q    <= 2'd0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            drop_q  <= 1'b0;
            valid_q <= 4'b0;
            tag_q   <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_jtdd_sdram_sched.sv
// tb_jtdd_sdram_sched: directed checks of caching, arbitration, download and reset behaviour
module tb_jtdd_sdram_sched;
    localparam int AW = 22;
    localparam int DW = 32;
    logic          clk = 1'b0, rst = 1'b1, downloading = 1'b0;
    logic [3:0]    slot_cs = 4'b0, slot_ok;
    logic [AW-1:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0, sdram_addr;
    logic [DW-1:0] d0, d1, d2, d3, data_read = '0;
    logic          sdram_req, sdram_ack = 1'b0, data_rdy = 1'b0;
    int            tests = 0, fails = 0;

    jtdd_sdram_sched #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(slot_cs),
        .slot0_addr(a0), .slot1_addr(a1), .slot2_addr(a2), .slot3_addr(a3),
        .slot_ok(slot_ok), .slot0_dout(d0), .slot1_dout(d1), .slot2_dout(d2), .slot3_dout(d3),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [AW-1:0] exp_addr);
        int n = 0;
        while (!sdram_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 64'(sdram_req), 64'd1);
        chk({tag, "_addr"}, 64'(sdram_addr), 64'(exp_addr));
    endtask

    task automatic serve(input logic [DW-1:0] d);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk("req_drop_after_ack", 64'(sdram_req), 64'd0);
        @(negedge clk);
        data_rdy  = 1'b1;
        data_read = d;
        @(negedge clk);
        data_rdy = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(sdram_req), 64'd0);
        chk("rst_addr", 64'(sdram_addr), 64'd0);
        chk("rst_dout", {d0, d3}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        slot_cs = 4'b0001;
        a0 = 22'h28000;
        #1;
        chk("miss_ok0", 64'(slot_ok), 64'd0);
        chk("miss_req0", 64'(sdram_req), 64'd0);
        @(negedge clk);
        chk("miss_req_cycle1", 64'(sdram_req), 64'd1);
        chk("miss_addr", 64'(sdram_addr), 64'h28000);
        @(negedge clk);
        chk("miss_req_hold", 64'(sdram_req), 64'd1);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk("miss_req_after_ack", 64'(sdram_req), 64'd0);
        repeat (4) @(negedge clk);
        chk("miss_ok_before_data", 64'(slot_ok), 64'd0);
        data_rdy  = 1'b1;
        data_read = 32'hDEADBEEF;
        @(negedge clk);
        data_rdy = 1'b0;
        chk("miss_ok_after_data", 64'(slot_ok), 64'b0001);
        chk("miss_dout", 64'(d0), 64'hDEADBEEF);

        repeat (4) @(negedge clk);
        chk("hit_no_req", 64'(sdram_req), 64'd0);
        chk("hit_ok", 64'(slot_ok), 64'b0001);
        a0 = 22'h28001;
        #1;
        chk("hit_change_ok", 64'(slot_ok), 64'd0);
        @(negedge clk);
        chk("rereq", 64'(sdram_req), 64'd1);
        chk("rereq_addr", 64'(sdram_addr), 64'h28001);
        serve(32'h11111111);
        chk("rereq_ok", 64'(slot_ok), 64'b0001);
        chk("rereq_dout", 64'(d0), 64'h11111111);

        rst = 1'b1;
        slot_cs = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        a0 = 22'h100; a1 = 22'h101; a2 = 22'h102; a3 = 22'h103;
        slot_cs = 4'b1111;
        wait_req("rr0_g0", 22'h100); serve(32'hC0);
        wait_req("rr0_g1", 22'h101); serve(32'hC1);
        wait_req("rr0_g2", 22'h102); serve(32'hC2);
        wait_req("rr0_g3", 22'h103); serve(32'hC3);
        chk("rr0_ok", 64'(slot_ok), 64'b1111);
        chk("rr0_dout2", 64'(d2), 64'hC2);

        slot_cs = 4'b0001;
        a0 = 22'h200;
        wait_req("rr1_pre", 22'h200); serve(32'hA0);
        a0 = 22'h204; a1 = 22'h201; a2 = 22'h202; a3 = 22'h203;
        slot_cs = 4'b1111;
        wait_req("rr1_g1", 22'h201); serve(32'hA1);
        wait_req("rr1_g2", 22'h202); serve(32'hA2);
        wait_req("rr1_g3", 22'h203); serve(32'hA3);
        wait_req("rr1_g0", 22'h204); serve(32'hA4);
        chk("rr1_ok", 64'(slot_ok), 64'b1111);
        chk("rr1_dout0", 64'(d0), 64'hA4);

        slot_cs = 4'b0001;
        a0 = 22'h300;
        wait_req("same", 22'h300);
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        data_read = 32'h3030;
        @(negedge clk);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        chk("same_req", 64'(sdram_req), 64'd0);
        chk("same_ok", 64'(slot_ok), 64'b0001);
        chk("same_dout", 64'(d0), 64'h3030);

        slot_cs = 4'b0100;
        a2 = 22'h50000;
        wait_req("mid", 22'h50000);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        a2 = 22'h50010;
        @(negedge clk);
        data_rdy  = 1'b1;
        data_read = 32'h5A5A;
        @(negedge clk);
        data_rdy = 1'b0;
        chk("mid_ok", 64'(slot_ok), 64'd0);
        chk("mid_dout", 64'(d2), 64'h5A5A);
        wait_req("mid_rereq", 22'h50010);
        a2 = 22'h50000;
        #1;
        chk("mid_tag", 64'(slot_ok), 64'b0100);
        a2 = 22'h50010;
        #1;
        serve(32'h5B5B);
        chk("mid_fill_ok", 64'(slot_ok), 64'b0100);

        slot_cs = 4'b0110;
        a1 = 22'h6000;
        #1;
        chk("dl_pre_ok", 64'(slot_ok), 64'b0100);
        wait_req("dl_ack", 22'h6000);
        downloading = 1'b1;
        @(negedge clk);
        chk("dl_ack_req", 64'(sdram_req), 64'd0);
        chk("dl_ack_ok", 64'(slot_ok), 64'd0);
        repeat (3) @(negedge clk);
        chk("dl_hold_req", 64'(sdram_req), 64'd0);
        downloading = 1'b0;
        slot_cs = 4'b0010;
        wait_req("dl_rereq", 22'h6000);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        downloading = 1'b1;
        @(negedge clk);
        downloading = 1'b0;
        chk("dl_data_req", 64'(sdram_req), 64'd0);
        @(negedge clk);
        data_rdy  = 1'b1;
        data_read = 32'h6666;
        @(negedge clk);
        data_rdy = 1'b0;
        chk("dl_discard_ok", 64'(slot_ok), 64'd0);
        chk("dl_discard_dout", 64'(d1), 64'hA1);
        wait_req("dl_after", 22'h6000);
        serve(32'h6161);
        chk("dl_after_ok", 64'(slot_ok), 64'b0010);
        chk("dl_after_dout", 64'(d1), 64'h6161);

        slot_cs = 4'b1000;
        a3 = 22'h7000;
        wait_req("rstd", 22'h7000);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        slot_cs = 4'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstd_req", 64'(sdram_req), 64'd0);
        chk("rstd_addr", 64'(sdram_addr), 64'd0);
        chk("rstd_dout01", {d0, d1}, 64'd0);
        chk("rstd_dout23", {d2, d3}, 64'd0);
        data_rdy  = 1'b1;
        data_read = 32'h7777;
        @(negedge clk);
        data_rdy = 1'b0;
        slot_cs = 4'b1000;
        #1;
        chk("rstd_late_ok", 64'(slot_ok), 64'd0);
        chk("rstd_late_dout", 64'(d3), 64'd0);
        @(negedge clk);
        wait_req("rstd_rereq", 22'h7000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
